// File: rtl/ldpc_pkg.sv
// Shared constants and types for the QC-LDPC parity checker (and future encoder).
package ldpc_pkg;
  localparam int Z      = 360;           // circulant size / parity length / ROM row width
  localparam int NBLK   = 12;            // info groups
  localparam int K_INFO = NBLK * Z;      // 4320 info bits
  localparam int N_CODE = K_INFO + Z;    // 4680 codeword bits
  localparam int AW     = 4;             // G-ROM address width
  localparam int CW     = 9;             // mismatch count width (0..360)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INFO,
    ST_PARITY,
    ST_DONE
  } state_e;

  typedef logic [Z-1:0] row_t;
endpackage

// File: rtl/ldpc_qc_accum.sv
// Quasi-cyclic parity accumulator: XORs the current (rotated) G-ROM row into
// the running sum for every 1 info bit and rotates the row right once per bit.
module ldpc_qc_accum
  import ldpc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,          // one info bit presented this cycle
  input  logic i_clear,       // first bit of a word: start from a zero sum
  input  logic i_first,       // bit is position 0 of its group: use the ROM row
  input  logic i_bit,
  input  row_t i_rom_data,
  output row_t o_sum
);
  row_t r_sum;
  row_t r_rot_row;
  row_t w_row;
  row_t w_base;

  assign w_row  = i_first ? i_rom_data : r_rot_row;
  assign w_base = i_clear ? '0 : r_sum;
  assign o_sum  = r_sum;

  // Accumulate the row on a 1 bit, rotate it right for the next position
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum     <= '0;
      r_rot_row <= '0;
    end else if (i_en) begin
      r_sum     <= w_base ^ (i_bit ? w_row : '0);
      r_rot_row <= {w_row[0], w_row[Z-1:1]};
    end else if (i_clear) begin
      r_sum     <= '0;
      r_rot_row <= '0;
    end
  end
endmodule

// File: rtl/ldpc_parity_checker.sv
// Receive-side QC-LDPC parity checker: recomputes parity from 4320 serial info
// bits, compares against the 360 received parity bits, reports pass/fail and
// forwards the info bits.
// Build option LDPC_CHK_ERRCNT_EN: full 9-bit mismatch counter on o_err_cnt;
// when undefined a sticky mismatch flag is reported as {8'b0, flag}.
module ldpc_parity_checker
  import ldpc_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sop,
  input  logic          i_din_valid,
  input  logic          i_din,
  output logic [AW-1:0] o_rom_addr,
  input  logic [Z-1:0]  i_rom_data,
  output logic          o_info_valid,
  output logic          o_info_out,
  output logic          o_busy,
  output logic          o_chk_done,
  output logic          o_chk_pass,
  output logic [CW-1:0] o_err_cnt
);
  localparam logic [8:0]    ZM1   = 9'(Z - 1);
  localparam logic [AW-1:0] GLAST = AW'(NBLK - 1);

  state_e        r_state, w_state_nxt;
  logic [8:0]    r_pos;        // position in group during INFO, parity index j during PARITY
  logic [AW-1:0] r_grp;
  logic [AW-1:0] r_rom_addr;
  logic          r_info_valid, r_info_out;
  logic          r_pass;
  row_t          w_sum;

  logic w_in_word, w_sop_acc, w_info_bit, w_par_bit, w_first;
  logic w_last_info, w_last_par, w_mis, w_zero_nxt;

  // A sop restarts only when row 0 is already on the ROM bus
  assign w_in_word   = (r_state == ST_INFO) || (r_state == ST_PARITY);
  assign w_sop_acc   = i_din_valid && i_sop &&
                       ((r_state == ST_IDLE) || (w_in_word && (r_rom_addr == '0)));
  assign w_info_bit  = i_din_valid && (w_sop_acc || (r_state == ST_INFO));
  assign w_par_bit   = i_din_valid && !w_sop_acc && (r_state == ST_PARITY);
  assign w_first     = w_sop_acc || ((r_state == ST_INFO) && (r_pos == '0));
  assign w_last_info = w_info_bit && !w_sop_acc && (r_grp == GLAST) && (r_pos == ZM1);
  assign w_last_par  = w_par_bit && (r_pos == ZM1);
  // Parity arrives MSB first: j=0 pairs with sum[Z-1]
  assign w_mis       = w_par_bit && (i_din ^ w_sum[ZM1 - r_pos]);

  ldpc_qc_accum u_accum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (w_info_bit),
    .i_clear    (w_sop_acc),
    .i_first    (w_first),
    .i_bit      (i_din),
    .i_rom_data (i_rom_data),
    .o_sum      (w_sum)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_sop_acc) begin
      w_state_nxt = ST_INFO;
    end else begin
      case (r_state)
        ST_INFO:   if (w_last_info) w_state_nxt = ST_PARITY;
        ST_PARITY: if (w_last_par)  w_state_nxt = ST_DONE;
        ST_DONE:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    o_busy     = w_in_word;
    o_chk_done = (r_state == ST_DONE);
  end

  // Bit/group counters and ROM prefetch address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos      <= '0;
      r_grp      <= '0;
      r_rom_addr <= '0;
    end else if (w_sop_acc) begin
      r_pos      <= 9'd1;
      r_grp      <= '0;
      r_rom_addr <= AW'(1);
    end else if (w_info_bit) begin
      if (r_pos == '0)
        r_rom_addr <= (r_grp == GLAST) ? '0 : r_grp + AW'(1);
      if (r_pos == ZM1) begin
        r_pos <= '0;
        r_grp <= (r_grp == GLAST) ? '0 : r_grp + AW'(1);
      end else begin
        r_pos <= r_pos + 9'd1;
      end
    end else if (w_par_bit) begin
      r_pos <= (r_pos == ZM1) ? '0 : r_pos + 9'd1;
    end
  end

`ifdef LDPC_CHK_ERRCNT_EN
  logic [CW-1:0] r_err_cnt;

  // Full mismatch counter, cleared by an accepted sop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_err_cnt <= '0;
    else if (w_sop_acc) r_err_cnt <= '0;
    else if (w_mis)     r_err_cnt <= r_err_cnt + CW'(1);
  end

  assign w_zero_nxt = (r_err_cnt == '0) && !w_mis;
  assign o_err_cnt  = r_err_cnt;
`else
  logic r_err_flag;

  // Sticky mismatch flag, cleared by an accepted sop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_err_flag <= 1'b0;
    else if (w_sop_acc) r_err_flag <= 1'b0;
    else if (w_mis)     r_err_flag <= 1'b1;
  end

  assign w_zero_nxt = !r_err_flag && !w_mis;
  assign o_err_cnt  = {{(CW-1){1'b0}}, r_err_flag};
`endif

  // Verdict latched on the last parity bit so it is valid with chk_done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_pass <= 1'b0;
    else if (w_sop_acc)  r_pass <= 1'b0;
    else if (w_last_par) r_pass <= w_zero_nxt;
  end

  // Registered info-bit forwarding, one cycle latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_info_valid <= 1'b0;
      r_info_out   <= 1'b0;
    end else begin
      r_info_valid <= w_info_bit;
      if (w_info_bit) r_info_out <= i_din;
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_info_valid = r_info_valid;
  assign o_info_out   = r_info_out;
  assign o_chk_pass   = r_pass;
endmodule
